amba_axi4_lite_reg_slave: RTL and testbench

- AXI4-Lite subordinate register bank. It is the endpoint that the AXI4-Lite protocol checker and constraint agent observe.
- Consumes the AW, W and AR channels and produces the B and R channels, backed by NUM_REGS data-width registers.
- Serves as the formal DUT for the compare-VIP examples: it gives the checker a real responder to prove against.

---
 rtl/amba_axi4_lite_reg_slave.sv | 208 ++++++++++++++++++++
 tb/tb_amba_axi4_lite_reg_slave.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/amba_axi4_lite_reg_slave.sv
// ============================================================================
// Module   : amba_axi4_lite_reg_slave
// Purpose  : AXI4-Lite subordinate backed by NUM_REGS data-width registers.
// Option   : AMBA_AXI4_LITE_REG_SLAVE_SLVERR_EN -> SLVERR on out-of-range access
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module amba_axi4_lite_reg_slave #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGS      = 8
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [ADDRESS_WIDTH-1:0]   AWADDR,
  input  logic [2:0]                 AWPROT,
  input  logic                       AWVALID,
  output logic                       AWREADY,
  input  logic [DATA_WIDTH-1:0]      WDATA,
  input  logic [DATA_WIDTH/8-1:0]    WSTRB,
  input  logic                       WVALID,
  output logic                       WREADY,
  output logic [1:0]                 BRESP,
  output logic                       BVALID,
  input  logic                       BREADY,
  input  logic [ADDRESS_WIDTH-1:0]   ARADDR,
  input  logic [2:0]                 ARPROT,
  input  logic                       ARVALID,
  output logic                       ARREADY,
  output logic [DATA_WIDTH-1:0]      RDATA,
  output logic [1:0]                 RRESP,
  output logic                       RVALID,
  input  logic                       RREADY
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int IDX_W      = $clog2(NUM_REGS);

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AMBA_AXI4_LITE_REG_SLAVE_SLVERR_EN
  localparam logic [1:0] RESP_OOR  = 2'b10;
`else
  localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

  localparam logic [1:0] W_IDLE    = 2'd0;
  localparam logic [1:0] W_HAVE_AW = 2'd1;
  localparam logic [1:0] W_HAVE_W  = 2'd2;
  localparam logic [1:0] W_RESP    = 2'd3;

  localparam logic       R_IDLE    = 1'b0;
  localparam logic       R_RESP    = 1'b1;

  function automatic logic in_range(input logic [ADDRESS_WIDTH-1:0] a);
    return (a >> (ADDR_LSB + IDX_W)) == '0;
  endfunction

  function automatic logic [IDX_W-1:0] reg_idx(input logic [ADDRESS_WIDTH-1:0] a);
    return a[ADDR_LSB +: IDX_W];
  endfunction

  logic [DATA_WIDTH-1:0]    regs [NUM_REGS];

  logic [1:0]               wstate;
  logic [ADDRESS_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0]    w_data;
  logic [STRB_WIDTH-1:0]    w_strb;

  logic                     rstate;

  logic                     aw_hs;
  logic                     w_hs;
  logic                     ar_hs;

  logic                     commit_en;
  logic [ADDRESS_WIDTH-1:0] commit_addr;
  logic [DATA_WIDTH-1:0]    commit_data;
  logic [STRB_WIDTH-1:0]    commit_strb;
  logic                     commit_ok;
  logic [IDX_W-1:0]         commit_idx;

  logic                     unused_prot;

  assign unused_prot = ^{AWPROT, ARPROT};

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign ar_hs = ARVALID && ARREADY;

  // Merge the live channel with whichever half was latched earlier.
  always_comb begin
    commit_en   = 1'b0;
    commit_addr = AWADDR;
    commit_data = WDATA;
    commit_strb = WSTRB;
    case (wstate)
      W_IDLE:    commit_en = aw_hs && w_hs;
      W_HAVE_AW: begin
        commit_en   = w_hs;
        commit_addr = aw_addr;
      end
      W_HAVE_W:  begin
        commit_en   = aw_hs;
        commit_data = w_data;
        commit_strb = w_strb;
      end
      default:   commit_en = 1'b0;
    endcase
  end

  assign commit_ok  = in_range(commit_addr);
  assign commit_idx = reg_idx(commit_addr);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate  <= W_IDLE;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BRESP   <= RESP_OKAY;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else if (commit_en) begin
      wstate  <= W_RESP;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b1;
      BRESP   <= commit_ok ? RESP_OKAY : RESP_OOR;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (aw_hs) begin
            aw_addr <= AWADDR;
            wstate  <= W_HAVE_AW;
            AWREADY <= 1'b0;
            WREADY  <= 1'b1;
          end else if (w_hs) begin
            w_data  <= WDATA;
            w_strb  <= WSTRB;
            wstate  <= W_HAVE_W;
            AWREADY <= 1'b1;
            WREADY  <= 1'b0;
          end else begin
            AWREADY <= 1'b1;
            WREADY  <= 1'b1;
          end
        end
        W_RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            wstate  <= W_IDLE;
            AWREADY <= 1'b1;
            WREADY  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Out-of-range commits leave every register untouched.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else if (commit_en && commit_ok) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (commit_strb[b]) regs[commit_idx][8*b +: 8] <= commit_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rstate  <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RDATA   <= '0;
      RRESP   <= RESP_OKAY;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (ar_hs) begin
            rstate  <= R_RESP;
            ARREADY <= 1'b0;
            RVALID  <= 1'b1;
            RDATA   <= in_range(ARADDR) ? regs[reg_idx(ARADDR)] : '0;
            RRESP   <= in_range(ARADDR) ? RESP_OKAY : RESP_OOR;
          end else begin
            ARREADY <= 1'b1;
          end
        end
        default: begin
          if (RREADY) begin
            rstate  <= R_IDLE;
            RVALID  <= 1'b0;
            ARREADY <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_amba_axi4_lite_reg_slave.sv
// ============================================================================
// Module   : tb_amba_axi4_lite_reg_slave
// Purpose  : Directed bench with a register-array model and a per-cycle checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_amba_axi4_lite_reg_slave;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [31:0] AWADDR = '0;
  logic [2:0]  AWPROT = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [31:0] ARADDR = '0;
  logic [2:0]  ARPROT = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY = 1'b0;

  amba_axi4_lite_reg_slave #(
    .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(8)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

`ifdef AMBA_AXI4_LITE_REG_SLAVE_SLVERR_EN
  localparam logic [1:0] OOR = 2'b10;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif

  int checks = 0;
  int passes = 0;

  // Model: eight 32-bit words at byte addresses 0x00..0x1C.
  logic [31:0] model [8];
  logic [1:0]  exp_b_q [$];
  logic [33:0] exp_r_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic bit model_in_range(input logic [31:0] a);
    return a < 32'd32;
  endfunction

  function automatic logic [33:0] model_read(input logic [31:0] a);
    if (model_in_range(a)) return {2'b00, model[a / 4]};
    return {OOR, 32'h0};
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (model_in_range(a)) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) model[a / 4][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  // Per-cycle checker against the queued expectations.
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (BVALID) begin
        chk("b_readys_low", {AWREADY, WREADY}, 2'b00);
        if (exp_b_q.size() == 0) chk("b_unexpected", 1, 0);
        else begin
          chk("bresp", BRESP, exp_b_q[0]);
          if (BREADY) void'(exp_b_q.pop_front());
        end
      end
      if (RVALID) begin
        chk("r_arready_low", ARREADY, 1'b0);
        if (exp_r_q.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          chk("rdata_rresp", {RRESP, RDATA}, exp_r_q[0]);
          if (RREADY) void'(exp_r_q.pop_front());
        end
      end
    end
  end

  task automatic write_tx(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_delay, input int w_delay, input int b_hold);
    bit aw_done = 0, w_done = 0, aw_f, w_f, b_f, seen_b = 0, fin = 0;
    int commit_cyc = -1, bv_cnt = 0;
    exp_b_q.push_back(model_in_range(a) ? 2'b00 : OOR);
    for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
      AWVALID = !aw_done && cyc >= aw_delay;
      AWADDR  = a;
      WVALID  = !w_done && cyc >= w_delay;
      WDATA   = d;
      WSTRB   = s;
      BREADY  = bv_cnt >= b_hold;
      @(negedge ACLK);
      if (aw_done && !w_done) chk("awready_have_aw", AWREADY, 1'b0);
      if (w_done && !aw_done) chk("wready_have_w", WREADY, 1'b0);
      if (BVALID && !seen_b) begin
        seen_b = 1;
        chk("b_latency", cyc - commit_cyc, 1);
      end
      if (BVALID) bv_cnt++;
      aw_f = AWVALID && AWREADY;
      w_f  = WVALID && WREADY;
      b_f  = BVALID && BREADY;
      @(posedge ACLK); #1;
      if (!(aw_done && w_done) && (aw_done || aw_f) && (w_done || w_f)) begin
        commit_cyc = cyc;
        model_write(a, d, s);
      end
      aw_done |= aw_f;
      w_done  |= w_f;
      fin = b_f;
    end
    if (!fin) chk("write_timeout", 0, 1);
    AWVALID = 0; WVALID = 0; BREADY = 0;
  endtask

  task automatic read_tx(input logic [31:0] a, input int r_hold, output logic [31:0] got);
    bit ar_done = 0, ar_f, r_f, fin = 0;
    int rv_cnt = 0;
    got = 'x;
    exp_r_q.push_back(model_read(a));
    for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
      ARVALID = !ar_done;
      ARADDR  = a;
      RREADY  = rv_cnt >= r_hold;
      @(negedge ACLK);
      if (ar_done && !RVALID) chk("r_latency", RVALID, 1'b1);
      if (RVALID) rv_cnt++;
      ar_f = ARVALID && ARREADY;
      r_f  = RVALID && RREADY;
      if (r_f) got = RDATA;
      @(posedge ACLK); #1;
      ar_done |= ar_f;
      fin = r_f;
    end
    if (!fin) chk("read_timeout", 0, 1);
    ARVALID = 0; RREADY = 0;
  endtask

  logic [31:0] rd;

  initial begin
    for (int i = 0; i < 8; i++) model[i] = '0;

    // Reset held three cycles.
    ARESET = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("reset_outputs", {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA}, '0);
    end
    @(posedge ACLK); #1;
    ARESET = 0;
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("readys_after_reset", {AWREADY, WREADY, ARREADY}, 3'b111);
    @(posedge ACLK); #1;
    read_tx(32'h0, 0, rd);
    chk("lit_reset_read", rd, 32'h0);

    // Simultaneous AW/W.
    write_tx(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    read_tx(32'h4, 0, rd);
    chk("lit_read_4", rd, 32'hDEADBEEF);
    chk("model_pin_4", model[1], 32'hDEADBEEF);

    // W leads AW by three cycles with a partial strobe.
    write_tx(32'h8, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    write_tx(32'h8, 32'h11223344, 4'b0101, 3, 0, 0);
    read_tx(32'h8, 0, rd);
    chk("lit_read_8", rd, 32'hFF22FF44);

    // AW leads W; then an all-zero strobe.
    write_tx(32'h1C, 32'hCAFE0001, 4'b1100, 0, 2, 0);
    write_tx(32'h1C, 32'h12345678, 4'h0, 0, 0, 0);
    read_tx(32'h1C, 0, rd);
    chk("lit_read_1c", rd, 32'hCAFE0000);

    // Out of range: no register changes anywhere.
    write_tx(32'h40, 32'h12345678, 4'hF, 0, 0, 0);
    read_tx(32'h40, 0, rd);
    chk("lit_read_oor", rd, 32'h0);
    for (int i = 0; i < 8; i++) read_tx(32'(i * 4), 0, rd);

    // Backpressure on both response channels.
    fork
      write_tx(32'h10, 32'h0BADF00D, 4'hF, 0, 0, 5);
      read_tx(32'h4, 5, rd);
    join
    read_tx(32'h10, 0, rd);
    chk("lit_read_10", rd, 32'h0BADF00D);

    // Same-edge read and write commit to one register.
    write_tx(32'hC, 32'h1, 4'hF, 0, 0, 0);
    fork
      write_tx(32'hC, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
      read_tx(32'hC, 0, rd);
    join
    chk("lit_read_pre_write", rd, 32'h1);
    read_tx(32'hC, 0, rd);
    chk("lit_read_post_write", rd, 32'hA5A5A5A5);

    repeat (3) @(posedge ACLK);
    chk("queues_drained", exp_b_q.size() + exp_r_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
